// File: rtl/uart_port_sched.sv
// Sequencer/arbiter owning the 4-register UART port: boot dummy write, RX polling,
// round-robin TX between requesters A and B, and a valid/ready RX character output.

module uart_port_sched #(
  // Idle cycles after each TX write before the next TX status poll; legal range 2..15.
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       a_tx_valid,
  input  logic [7:0] a_tx_data,
  output logic       a_tx_ready,

  input  logic       b_tx_valid,
  input  logic [7:0] b_tx_data,
  output logic       b_tx_ready,

  output logic       rx_valid,
  output logic [6:0] rx_data,
  input  logic       rx_ready,

  output logic [1:0] uart_address,
  output logic       uart_w_en,
  output logic       uart_enable,
  output logic [7:0] uart_din,
  input  logic [7:0] uart_dout
);

  localparam logic [1:0] AddrRx   = 2'd0;
  localparam logic [1:0] AddrRxcr = 2'd1;
  localparam logic [1:0] AddrTx   = 2'd2;
  localparam logic [1:0] AddrTxcr = 2'd3;

  localparam logic [3:0] GuardLast = 4'(GUARD_CYCLES - 1);

  typedef enum logic [3:0] {
    StBoot,
    StInit,
    StIdle,
    StRxsSet,
    StRxsChk,
    StRxRd,
    StRxCap,
    StTxArb,
    StTxsSet,
    StTxsChk,
    StTxWr,
    StTxGuard
  } state_e;

  state_e     state_q;
  logic       ptr_q;        // last requester served: 0 = A, 1 = B
  logic       grant_q;      // current grant: 0 = A, 1 = B
  logic       grant_vld_q;  // a latched byte is waiting for the UART
  logic [6:0] tx_byte_q;
  logic [3:0] guard_q;
  logic       rx_valid_q;
  logic [6:0] rx_data_q;

  logic       arb_pick;

  // The UART link is 7-bit; the requester MSBs are never transmitted.
  logic unused_tx_msb;
  assign unused_tx_msb = a_tx_data[7] ^ b_tx_data[7];

  // Tie goes to the requester opposite the last one served.
  always_comb begin
    arb_pick = 1'b0;
    if (a_tx_valid && b_tx_valid) begin
      arb_pick = ~ptr_q;
    end else begin
      arb_pick = b_tx_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBoot;
      ptr_q       <= 1'b1;
      grant_q     <= 1'b0;
      grant_vld_q <= 1'b0;
      tx_byte_q   <= 7'h00;
      guard_q     <= 4'd0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 7'h00;
    end else begin
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        StBoot: state_q <= StInit;
        StInit: state_q <= StIdle;

        // The UART holds an unread byte (and CTS) while the consumer is stalled.
        StIdle: state_q <= rx_valid_q ? StTxArb : StRxsSet;

        StRxsSet: state_q <= StRxsChk;
        StRxsChk: state_q <= uart_dout[7] ? StRxRd : StTxArb;
        StRxRd:   state_q <= StRxCap;

        StRxCap: begin
          rx_data_q  <= uart_dout[6:0];
          rx_valid_q <= 1'b1;
          state_q    <= StTxArb;
        end

        // A grant retained across a busy retry is reused without re-arbitration.
        StTxArb: begin
          if (grant_vld_q) begin
            state_q <= StTxsSet;
          end else if (a_tx_valid || b_tx_valid) begin
            grant_q     <= arb_pick;
            grant_vld_q <= 1'b1;
            tx_byte_q   <= arb_pick ? b_tx_data[6:0] : a_tx_data[6:0];
            state_q     <= StTxsSet;
          end else begin
            state_q <= StIdle;
          end
        end

        StTxsSet: state_q <= StTxsChk;
        StTxsChk: state_q <= uart_dout[7] ? StIdle : StTxWr;

        StTxWr: begin
          ptr_q       <= grant_q;
          grant_vld_q <= 1'b0;
          guard_q     <= 4'd0;
          state_q     <= StTxGuard;
        end

        StTxGuard: begin
          if (guard_q == GuardLast) begin
            guard_q <= 4'd0;
            state_q <= StIdle;
          end else begin
            guard_q <= guard_q + 4'd1;
          end
        end

        default: state_q <= StBoot;
      endcase
    end
  end

  always_comb begin
    uart_address = AddrTxcr;
    uart_w_en    = 1'b0;
    uart_enable  = 1'b0;
    uart_din     = 8'h00;
    a_tx_ready   = 1'b0;
    b_tx_ready   = 1'b0;

    case (state_q)
      // The UART swallows the first TX write after reset.
      StInit: begin
        uart_address = AddrTx;
        uart_w_en    = 1'b1;
        uart_enable  = 1'b1;
      end

      StRxsSet, StRxsChk: uart_address = AddrRxcr;

      StRxRd: begin
        uart_address = AddrRx;
        uart_enable  = 1'b1;
      end

      StTxsSet, StTxsChk: uart_address = AddrTx;

      StTxWr: begin
        uart_address = AddrTx;
        uart_w_en    = 1'b1;
        uart_din     = {1'b0, tx_byte_q};
        a_tx_ready   = ~grant_q;
        b_tx_ready   = grant_q;
      end

      default: ;
    endcase
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_uart_port_sched.sv
// Bench for uart_port_sched: a registered-read UART model, two TX requesters and an RX
// consumer, with expected writes and characters queued as stimulus is issued.

module tb_uart_port_sched;

  localparam int unsigned GUARD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_tx_valid = 1'b0;
  logic [7:0] a_tx_data = 8'h00;
  logic       a_tx_ready;
  logic       b_tx_valid = 1'b0;
  logic [7:0] b_tx_data = 8'h00;
  logic       b_tx_ready;
  logic       rx_valid;
  logic [6:0] rx_data;
  logic       rx_ready = 1'b0;
  logic [1:0] uart_address;
  logic       uart_w_en;
  logic       uart_enable;
  logic [7:0] uart_din;
  logic [7:0] uart_dout = 8'h00;

  uart_port_sched #(
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .a_tx_valid  (a_tx_valid),
    .a_tx_data   (a_tx_data),
    .a_tx_ready  (a_tx_ready),
    .b_tx_valid  (b_tx_valid),
    .b_tx_data   (b_tx_data),
    .b_tx_ready  (b_tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .uart_address(uart_address),
    .uart_w_en   (uart_w_en),
    .uart_enable (uart_enable),
    .uart_din    (uart_din),
    .uart_dout   (uart_dout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboards: {requester (1 = B), byte} for TX writes; 7-bit characters for RX.
  logic [8:0] tx_sb[$];
  logic [6:0] rx_sb[$];
  logic [7:0] src_a[$];
  logic [7:0] src_b[$];

  // UART model state
  int         busy_req = 0;
  int         busy_done = 0;
  int         rx_push = 0;
  int         rx_acked = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] dout_next = 8'h00;
  logic [1:0] prev_addr = 2'd3;

  // Observation counters
  int cyc = 0;
  int init_cnt = 0;
  int txwr_cnt = 0;
  int rxrd_cnt = 0;
  int rxcr_cnt = 0;
  int txs_cnt = 0;
  int last_rxs = 0;
  int last_lat = -1;
  int wr_cyc = 0;
  int last_gap = -1;
  bit gap_pend = 1'b0;
  bit a_rdy_seen = 1'b0;
  bit b_rdy_seen = 1'b0;

  task automatic bg_negedge();
    logic [8:0]  e;
    logic [13:0] act;
    logic [13:0] req;
    bit          txwr;
    cyc++;
    case (uart_address)
      2'd0: dout_next = rx_byte;
      2'd1: dout_next = (rx_acked < rx_push) ? 8'h80 : 8'h00;
      2'd2: begin
        if (uart_w_en === 1'b0 && prev_addr != 2'd2 && busy_done < busy_req) begin
          dout_next = 8'h80;
          busy_done++;
        end else begin
          dout_next = 8'h00;
        end
      end
      default: dout_next = 8'h00;
    endcase
    if (uart_enable === 1'b1 && uart_w_en === 1'b0 && uart_address == 2'd0) begin
      rx_acked++;
      rxrd_cnt++;
    end
    if (uart_address == 2'd1) begin
      rxcr_cnt++;
      if (prev_addr != 2'd1) last_rxs = cyc;
    end
    if (uart_address == 2'd2 && uart_w_en === 1'b0 && prev_addr != 2'd2) txs_cnt++;

    if (uart_w_en === 1'b1 || uart_enable === 1'b1) begin
      n_cmp++;
      if (!((uart_address == 2'd2 && uart_w_en === 1'b1) ||
            (uart_address == 2'd0 && uart_w_en === 1'b0 && uart_enable === 1'b1))) begin
        n_bad++;
        $display("FAIL strobe_decode: addr=%0d w_en=%b enable=%b, required TX write or RX read",
                 uart_address, uart_w_en, uart_enable);
      end
    end
    if (uart_w_en === 1'b1 && uart_enable === 1'b1) begin
      init_cnt++;
      n_cmp++;
      if (uart_din !== 8'h00 || uart_address !== 2'd2) begin
        n_bad++;
        $display("FAIL init_write: addr=%0d din=%h, required addr=2 din=00", uart_address, uart_din);
      end
    end

    txwr = (uart_w_en === 1'b1 && uart_enable === 1'b0);
    if (txwr || a_tx_ready === 1'b1 || b_tx_ready === 1'b1) begin
      txwr_cnt++;
      wr_cyc   = cyc;
      gap_pend = 1'b1;
      last_lat = cyc - last_rxs;
      act = {uart_address, uart_w_en, uart_enable, uart_din, a_tx_ready, b_tx_ready};
      n_cmp++;
      if (tx_sb.size() == 0) begin
        n_bad++;
        $display("FAIL tx_unexpected: addr/w_en/en/din/ra/rb=%h, required no write", act);
      end else begin
        e   = tx_sb.pop_front();
        req = {2'd2, 1'b1, 1'b0, 1'b0, e[6:0], ~e[8], e[8]};
        if (act !== req) begin
          n_bad++;
          $display("FAIL tx_write: addr/w_en/en/din/ra/rb=%h, required %h", act, req);
        end
      end
      n_cmp++;
      if (busy_done != busy_req) begin
        n_bad++;
        $display("FAIL tx_while_busy: %0d busy polls served, required %0d", busy_done, busy_req);
      end
    end else if (gap_pend && uart_address != 2'd3) begin
      last_gap = cyc - wr_cyc;
      gap_pend = 1'b0;
    end

    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      n_cmp++;
      if (rx_sb.size() == 0) begin
        n_bad++;
        $display("FAIL rx_unexpected: rx_data=%h accepted, required none", rx_data);
      end else begin
        e[6:0] = rx_sb.pop_front();
        if (rx_data !== e[6:0]) begin
          n_bad++;
          $display("FAIL rx_char: rx_data=%h, required %h", rx_data, e[6:0]);
        end
      end
    end

    a_rdy_seen = (a_tx_ready === 1'b1);
    b_rdy_seen = (b_tx_ready === 1'b1);
    prev_addr  = uart_address;
  endtask

  // Requesters hold valid/data until their ready pulse, then load the next queued byte.
  task automatic bg_posedge();
    uart_dout = dout_next;
    if (a_rdy_seen) a_tx_valid = 1'b0;
    if (!a_tx_valid && src_a.size() > 0) begin
      a_tx_data  = src_a.pop_front();
      a_tx_valid = 1'b1;
    end
    if (b_rdy_seen) b_tx_valid = 1'b0;
    if (!b_tx_valid && src_b.size() > 0) begin
      b_tx_data  = src_b.pop_front();
      b_tx_valid = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_sb(input string name, input int left, input int budget);
    int i = 0;
    while (tx_sb.size() > left && i < budget) begin
      step();
      i++;
    end
    n_cmp++;
    if (tx_sb.size() > left) begin
      n_bad++;
      $display("FAIL %s: %0d writes pending after %0d cycles, required %0d", name, tx_sb.size(),
               budget, left);
      tx_sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({uart_address, uart_w_en, uart_enable, uart_din, a_tx_ready, b_tx_ready, rx_valid,
         rx_data} !== {2'd3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00}) begin
      n_bad++;
      $display("FAIL reset_outputs: addr=%0d w_en=%b en=%b din=%h rdy=%b%b rxv=%b rxd=%h, required defaults",
               uart_address, uart_w_en, uart_enable, uart_din, a_tx_ready, b_tx_ready, rx_valid,
               rx_data);
    end
    rst = 1'b0;
    n_cmp++;
    if ({uart_address, uart_w_en, uart_enable, uart_din} !== {2'd3, 1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL boot_outputs: addr=%0d w_en=%b en=%b din=%h, required 3/0/0/00",
               uart_address, uart_w_en, uart_enable, uart_din);
    end
    step();
    n_cmp++;
    if ({uart_address, uart_w_en, uart_enable, uart_din} !== {2'd2, 1'b1, 1'b1, 8'h00}) begin
      n_bad++;
      $display("FAIL init_cycle: addr=%0d w_en=%b en=%b din=%h, required 2/1/1/00",
               uart_address, uart_w_en, uart_enable, uart_din);
    end
    step();
    n_cmp++;
    if ({uart_w_en, uart_enable} !== 2'b00) begin
      n_bad++;
      $display("FAIL after_init: w_en=%b en=%b, required 0/0", uart_w_en, uart_enable);
    end
    repeat (24) step();
    n_cmp++;
    if (init_cnt != 1) begin
      n_bad++;
      $display("FAIL init_count: %0d INIT writes, required 1", init_cnt);
    end
    n_cmp++;
    if (txwr_cnt != 0) begin
      n_bad++;
      $display("FAIL idle_no_tx: %0d TX writes, required 0", txwr_cnt);
    end
    n_cmp++;
    if (rxcr_cnt < 8) begin
      n_bad++;
      $display("FAIL rxcr_polling: %0d RXCR cycles, required at least 8", rxcr_cnt);
    end
  endtask

  // Pointer favours A after reset, so a simultaneous start alternates A,B,A,B.
  task automatic test_round_robin();
    int w0 = txwr_cnt;
    src_a.push_back(8'hB1); src_a.push_back(8'h33);
    src_b.push_back(8'h32); src_b.push_back(8'hF4);
    tx_sb.push_back({1'b0, 8'hB1});
    tx_sb.push_back({1'b1, 8'h32});
    tx_sb.push_back({1'b0, 8'h33});
    tx_sb.push_back({1'b1, 8'hF4});
    wait_sb("rr_order", 0, 200);
    n_cmp++;
    if (txwr_cnt - w0 != 4) begin
      n_bad++;
      $display("FAIL rr_count: %0d writes, required 4", txwr_cnt - w0);
    end
  endtask

  // A wins the tie, sees busy twice, and keeps its grant until written on the third poll.
  task automatic test_busy_retry();
    int t0;
    repeat (12) step();
    t0 = txs_cnt;
    busy_req += 2;
    src_a.push_back(8'hA4);
    src_b.push_back(8'hB4);
    tx_sb.push_back({1'b0, 8'hA4});
    tx_sb.push_back({1'b1, 8'hB4});
    wait_sb("busy_first", 1, 200);
    n_cmp++;
    if (txs_cnt - t0 != 3) begin
      n_bad++;
      $display("FAIL busy_attempts: %0d TX polls before A write, required 3", txs_cnt - t0);
    end
    wait_sb("busy_second", 0, 100);
  endtask

  // Latency counted from the RXS_SET cycle, one after IDLE entry.
  task automatic test_single();
    repeat (12) step();
    src_a.push_back(8'hC1);
    tx_sb.push_back({1'b0, 8'hC1});
    wait_sb("single_write", 0, 60);
    n_cmp++;
    if (last_lat != 5) begin
      n_bad++;
      $display("FAIL ready_latency: %0d cycles after RXS_SET, required 5", last_lat);
    end
    repeat (12) step();
    n_cmp++;
    if (last_gap != int'(GUARD) + 2) begin
      n_bad++;
      $display("FAIL guard_gap: next poll %0d cycles after write, required %0d", last_gap,
               GUARD + 2);
    end
  endtask

  task automatic test_rx();
    int r0;
    int c0;
    int i = 0;
    repeat (8) step();
    rx_byte = 8'hD5;
    rx_push++;
    rx_sb.push_back(7'h55);
    r0 = rxrd_cnt;
    while (rx_valid !== 1'b1 && i < 30) begin
      step();
      i++;
    end
    n_cmp++;
    if (rx_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rx_timeout: rx_valid=%b after 30 cycles, required 1", rx_valid);
    end
    c0 = rxcr_cnt;
    repeat (10) begin
      step();
      n_cmp++;
      if ({rx_valid, rx_data} !== {1'b1, 7'h55}) begin
        n_bad++;
        $display("FAIL rx_hold: rx_valid=%b rx_data=%h, required 1/55", rx_valid, rx_data);
      end
    end
    n_cmp++;
    if (rxrd_cnt - r0 != 1) begin
      n_bad++;
      $display("FAIL rx_read_count: %0d RX reads, required 1", rxrd_cnt - r0);
    end
    n_cmp++;
    if (rxcr_cnt != c0) begin
      n_bad++;
      $display("FAIL rx_no_poll: %0d RXCR cycles while held, required 0", rxcr_cnt - c0);
    end
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rx_clear: rx_valid=%b after accept, required 0", rx_valid);
    end
    n_cmp++;
    if (rx_sb.size() != 0) begin
      n_bad++;
      $display("FAIL rx_accepted: %0d characters pending, required 0", rx_sb.size());
    end
    repeat (10) step();
    n_cmp++;
    if (rxcr_cnt <= c0 || rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rx_resume: %0d new RXCR cycles rx_valid=%b, required >0 and 0",
               rxcr_cnt - c0, rx_valid);
    end
  endtask

  task automatic check_boot_init(input string name);
    step();
    n_cmp++;
    if ({uart_address, uart_w_en, uart_enable, a_tx_ready, b_tx_ready} !==
        {2'd3, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL %s_boot: addr=%0d w_en=%b en=%b rdy=%b%b, required 3/0/0/00", name,
               uart_address, uart_w_en, uart_enable, a_tx_ready, b_tx_ready);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if ({uart_address, uart_w_en, uart_enable, uart_din} !== {2'd2, 1'b1, 1'b1, 8'h00}) begin
      n_bad++;
      $display("FAIL %s_init: addr=%0d w_en=%b en=%b din=%h, required 2/1/1/00", name,
               uart_address, uart_w_en, uart_enable, uart_din);
    end
  endtask

  // Pointer is A on entry: B21 then A11; reset during guard, then during TXS_CHK of A12.
  // A wins the post-reset ties only if the pointer was reset to favour A.
  task automatic test_reset_abort();
    int i0;
    int k = 0;
    repeat (8) step();
    i0 = init_cnt;
    src_a.push_back(8'h11); src_a.push_back(8'h12);
    src_b.push_back(8'h21); src_b.push_back(8'h22);
    tx_sb.push_back({1'b1, 8'h21});
    tx_sb.push_back({1'b0, 8'h11});
    wait_sb("abort_pre", 0, 100);
    rst = 1'b1;
    check_boot_init("abort_guard");
    while (!(uart_address == 2'd2 && uart_w_en === 1'b0) && k < 20) begin
      step();
      k++;
    end
    step();
    n_cmp++;
    if (uart_address !== 2'd2 || uart_w_en !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_txs_chk: addr=%0d w_en=%b, required 2/0", uart_address, uart_w_en);
    end
    rst = 1'b1;
    check_boot_init("abort_chk");
    tx_sb.push_back({1'b0, 8'h12});
    tx_sb.push_back({1'b1, 8'h22});
    wait_sb("abort_post", 0, 100);
    n_cmp++;
    if (init_cnt - i0 != 2) begin
      n_bad++;
      $display("FAIL abort_init_count: %0d INIT writes, required 2", init_cnt - i0);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        bg_negedge();
        @(posedge clk);
        #1;
        bg_posedge();
      end
    join_none
    test_reset();
    test_round_robin();
    test_busy_retry();
    test_single();
    test_rx();
    test_reset_abort();
    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
